main_entry: RTL and testbench

- Synthesized entry-function wrapper exposing one externally callable function `f` through two handshaked channels.
- The request channel carries two 32-bit arguments.
- The response channel returns a 64-bit result equal to the concatenation {arg0, arg1}.
- Sits at the top of a generated design as the host-facing call interface. Only one call is in flight at a time.

---
 rtl/main_entry.sv | 78 +++++++
 tb/tb_main_entry.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/main_entry.sv
// rtl/main_entry.sv - host-facing call wrapper for function f: result = {arg0, arg1}
// One call in flight; IDLE accepts, RUN forms the result, RESP holds it until taken.
module main_entry #(
  parameter int ARG_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               f_req_valid,
  output logic               f_req_ready,
  output logic               f_req_busy,
  input  logic [ARG_W-1:0]   f_req_0,
  input  logic [ARG_W-1:0]   f_req_1,
  output logic               f_res_valid,
  input  logic               f_res_ready,
  output logic [2*ARG_W-1:0] f_res_0
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [ARG_W-1:0]   r_a0;
  logic [ARG_W-1:0]   r_a1;
  logic [2*ARG_W-1:0] r_result;
  logic               r_res_valid;
  logic               r_busy;
  logic               w_idle;

  // Ready is gated by rst so it reads low for the whole time reset is held.
  assign w_idle      = (r_state == S_IDLE);
  assign f_req_ready = w_idle & rst;
  assign f_req_busy  = r_busy;
  assign f_res_valid = r_res_valid;
  assign f_res_0     = r_result;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_a0        <= '0;
      r_a1        <= '0;
      r_result    <= '0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (f_req_valid) begin
            r_a0    <= f_req_0;
            r_a1    <= f_req_1;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_result    <= {r_a0, r_a1};
          r_res_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (f_res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_entry.sv
// tb/tb_main_entry.sv - scoreboard bench for main_entry
module tb_main_entry;

  localparam int ARG_W = 32;

  logic               clk;
  logic               rst;
  logic               f_req_valid;
  logic               f_req_ready;
  logic               f_req_busy;
  logic [ARG_W-1:0]   f_req_0;
  logic [ARG_W-1:0]   f_req_1;
  logic               f_res_valid;
  logic               f_res_ready;
  logic [2*ARG_W-1:0] f_res_0;

  logic [63:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  main_entry #(.ARG_W(ARG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .f_req_valid (f_req_valid),
    .f_req_ready (f_req_ready),
    .f_req_busy  (f_req_busy),
    .f_req_0     (f_req_0),
    .f_req_1     (f_req_1),
    .f_res_valid (f_res_valid),
    .f_res_ready (f_res_ready),
    .f_res_0     (f_res_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string name, input logic rdy, input logic vld, input logic bsy);
    check({name, "_ready"}, {63'd0, f_req_ready}, {63'd0, rdy});
    check({name, "_valid"}, {63'd0, f_res_valid}, {63'd0, vld});
    check({name, "_busy"},  {63'd0, f_req_busy},  {63'd0, bsy});
  endtask

  // Present a request in IDLE; it is accepted on the next edge.
  task automatic call(input logic [31:0] a0, input logic [31:0] a1, input bit expect_result);
    f_req_0     = a0;
    f_req_1     = a1;
    f_req_valid = 1'b1;
    if (expect_result) exp_q.push_back({a0, a1});
    tick();
    f_req_valid = 1'b0;
  endtask

  // Monitor: a response transfer happens on the edge after a cycle with valid & ready.
  always @(negedge clk) begin
    if (rst && f_res_valid && f_res_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_response", f_res_0, 64'hx);
      end else begin
        check("sb_result", f_res_0, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b0;
    f_req_valid = 1'b0;
    f_req_0     = '0;
    f_req_1     = '0;
    f_res_ready = 1'b0;
    tick();
    tick();
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    check("reset_res0", f_res_0, 64'h0);
    rst = 1'b1;
    #1;

    for (int i = 0; i < 20; i++) begin
      check_flags("quiet", 1'b1, 1'b0, 1'b0);
      tick();
    end

    // Basic call with fixed two-edge latency
    call(32'h1, 32'h2, 1'b1);
    check_flags("basic_run", 1'b0, 1'b0, 1'b1);
    f_res_ready = 1'b1;
    tick();
    check_flags("basic_resp", 1'b0, 1'b1, 1'b1);
    check("basic_res0", f_res_0, 64'h0000000100000002);
    tick();
    check_flags("basic_done", 1'b1, 1'b0, 1'b0);
    check("basic_retain", f_res_0, 64'h0000000100000002);

    // Back-pressure: result held stable for 10 cycles
    f_res_ready = 1'b0;
    call(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      check_flags("bp_hold", 1'b0, 1'b1, 1'b1);
      check("bp_res0", f_res_0, 64'hA5A5A5A55A5A5A5A);
      tick();
    end
    f_res_ready = 1'b1;
    tick();
    check_flags("bp_release", 1'b1, 1'b0, 1'b0);

    // Extremes, with ready asserted ahead of valid
    call(32'hFFFFFFFF, 32'h00000000, 1'b1);
    tick();
    check("ext_a_res0", f_res_0, 64'hFFFFFFFF00000000);
    tick();
    check_flags("ext_a_one_cycle", 1'b1, 1'b0, 1'b0);
    call(32'h00000000, 32'hFFFFFFFF, 1'b1);
    tick();
    check("ext_b_res0", f_res_0, 64'h00000000FFFFFFFF);
    tick();

    // Back-to-back: next request waits in RESP, accepted once IDLE returns
    call(32'h11111111, 32'h22222222, 1'b1);
    tick();
    f_req_0     = 32'hDEADBEEF;
    f_req_1     = 32'h12345678;
    f_req_valid = 1'b1;
    exp_q.push_back(64'hDEADBEEF12345678);
    tick();
    check_flags("b2b_idle", 1'b1, 1'b0, 1'b0);
    tick();
    f_req_valid = 1'b0;
    f_req_0     = 32'hBAADBAAD;
    f_req_1     = 32'h0BAD0BAD;
    check_flags("b2b_run", 1'b0, 1'b0, 1'b1);
    tick();
    check("b2b_res0", f_res_0, 64'hDEADBEEF12345678);
    tick();

    // Reset while in RESP discards the pending result
    f_res_ready = 1'b0;
    call(32'h0BADF00D, 32'hCAFEF00D, 1'b0);
    tick();
    check_flags("rstmid_resp", 1'b0, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_flags("rstmid_async", 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check_flags("rstmid_after", 1'b1, 1'b0, 1'b0);
    f_res_ready = 1'b1;
    call(32'h01234567, 32'h89ABCDEF, 1'b1);
    tick();
    check("rstmid_new_res0", f_res_0, 64'h0123456789ABCDEF);
    tick();
    check_flags("rstmid_new_done", 1'b1, 1'b0, 1'b0);

    tick();
    tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
